lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 255 +++++++++++++++++++++++++
 tb/tb_lsu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one load/store request at a time, checks it
// for legality and alignment, runs a single-beat memory access held until
// memAck (bounded by a timeout), and writes load results back to the
// register file.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inValid/inReady           request handshake (transfer when both high)
//   isLoad, isStore, funct3   opcode class and RV32I width code
//   baseAddr, offset          rs1 value and sign-extended immediate
//   storeData, rdAddr         rs2 value and load destination register
//   memReq..memBe             memory request (held stable until memAck)
//   memAck, memRdata          memory response
//   wrEn, wrAddr, wrData      register file write port
//   fault, faultCause, faultAddr  one-cycle fault report (01/10/11)
//   busy                      high in every state except IDLE
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] baseAddr,
    input  logic [31:0] offset,
    input  logic [31:0] storeData,
    input  logic [4:0]  rdAddr,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        wrEn,
    output logic [4:0]  wrAddr,
    output logic [31:0] wrData,
    output logic        fault,
    output logic [1:0]  faultCause,
    output logic [31:0] faultAddr,
    output logic        busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ACCESS    = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] FAULT     = 2'd3;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    logic [1:0]       state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;

    // Latched request fields needed after the transfer cycle.
    logic        rqLoad, rqLoadNxt;
    logic [2:0]  rqF3, rqF3Nxt;
    logic [31:0] rqAddr, rqAddrNxt;
    logic [4:0]  rqRd, rqRdNxt;

    logic        inReadyNxt, busyNxt, memReqNxt, memWeNxt, wrEnNxt, faultNxt;
    logic [31:0] memAddrNxt, memWdataNxt, wrDataNxt, faultAddrNxt;
    logic [3:0]  memBeNxt;
    logic [4:0]  wrAddrNxt;
    logic [1:0]  faultCauseNxt;

    // Request decode, evaluated on the incoming (not yet latched) fields.
    logic [31:0] effAddr;
    logic        loadF3Ok, storeF3Ok, illegal, misalign;
    logic [31:0] stWdata;
    logic [3:0]  stBe;

    assign effAddr   = baseAddr + offset;
    assign loadF3Ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
    assign storeF3Ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    assign illegal   = (isLoad == isStore) || (isLoad && !loadF3Ok) || (isStore && !storeF3Ok);
    assign misalign  = ((funct3[1:0] == 2'b01) && effAddr[0]) ||
                       ((funct3[1:0] == 2'b10) && (effAddr[1:0] != 2'b00));

    // Store lane replication and byte enables.
    always_comb begin
        stWdata = storeData;
        stBe    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                stWdata = {4{storeData[7:0]}};
                stBe    = 4'b0001 << effAddr[1:0];
            end
            2'b01: begin
                stWdata = {2{storeData[15:0]}};
                stBe    = effAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                stWdata = storeData;
                stBe    = 4'b1111;
            end
        endcase
    end

    // Select and extend the addressed lane of a load response.
    function automatic logic [31:0] loadExtract(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  loadExtract = {{24{b[7]}}, b};
            3'b001:  loadExtract = {{16{h[15]}}, h};
            3'b100:  loadExtract = {24'd0, b};
            3'b101:  loadExtract = {16'd0, h};
            default: loadExtract = d;
        endcase
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        stateNxt      = state;
        cntNxt        = cnt;
        rqLoadNxt     = rqLoad;
        rqF3Nxt       = rqF3;
        rqAddrNxt     = rqAddr;
        rqRdNxt       = rqRd;
        inReadyNxt    = inReady;
        busyNxt       = busy;
        memReqNxt     = memReq;
        memWeNxt      = memWe;
        memAddrNxt    = memAddr;
        memWdataNxt   = memWdata;
        memBeNxt      = memBe;
        wrEnNxt       = 1'b0;
        wrAddrNxt     = wrAddr;
        wrDataNxt     = wrData;
        faultNxt      = 1'b0;
        faultCauseNxt = 2'b00;
        faultAddrNxt  = 32'd0;

        case (state)
            IDLE: begin
                if (inValid) begin
                    rqLoadNxt  = isLoad;
                    rqF3Nxt    = funct3;
                    rqAddrNxt  = effAddr;
                    rqRdNxt    = rdAddr;
                    inReadyNxt = 1'b0;
                    busyNxt    = 1'b1;
                    if (illegal || misalign) begin
                        stateNxt      = FAULT;
                        faultNxt      = 1'b1;
                        faultCauseNxt = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        faultAddrNxt  = effAddr;
                    end else begin
                        stateNxt    = ACCESS;
                        cntNxt      = '0;
                        memReqNxt   = 1'b1;
                        memAddrNxt  = {effAddr[31:2], 2'b00};
                        memWeNxt    = isStore;
                        memWdataNxt = isStore ? stWdata : 32'd0;
                        memBeNxt    = isStore ? stBe : 4'b1111;
                    end
                end
            end
            ACCESS: begin
                // Ack is checked first so an ack on the last allowed cycle wins.
                if (memAck) begin
                    memReqNxt = 1'b0;
                    if (rqLoad) begin
                        stateNxt  = WRITEBACK;
                        wrEnNxt   = (rqRd != 5'd0);
                        wrAddrNxt = rqRd;
                        wrDataNxt = loadExtract(rqF3, rqAddr[1:0], memRdata);
                    end else begin
                        stateNxt   = IDLE;
                        inReadyNxt = 1'b1;
                        busyNxt    = 1'b0;
                    end
                end else if (cnt == CNT_LAST) begin
                    stateNxt      = FAULT;
                    memReqNxt     = 1'b0;
                    faultNxt      = 1'b1;
                    faultCauseNxt = CAUSE_TIMEOUT;
                    faultAddrNxt  = rqAddr;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                // WRITEBACK and FAULT each last exactly one cycle.
                stateNxt   = IDLE;
                inReadyNxt = 1'b1;
                busyNxt    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rqLoad     <= 1'b0;
            rqF3       <= 3'd0;
            rqAddr     <= 32'd0;
            rqRd       <= 5'd0;
            inReady    <= 1'b1;
            busy       <= 1'b0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= 32'd0;
            memWdata   <= 32'd0;
            memBe      <= 4'd0;
            wrEn       <= 1'b0;
            wrAddr     <= 5'd0;
            wrData     <= 32'd0;
            fault      <= 1'b0;
            faultCause <= 2'b00;
            faultAddr  <= 32'd0;
        end else begin
            state      <= stateNxt;
            cnt        <= cntNxt;
            rqLoad     <= rqLoadNxt;
            rqF3       <= rqF3Nxt;
            rqAddr     <= rqAddrNxt;
            rqRd       <= rqRdNxt;
            inReady    <= inReadyNxt;
            busy       <= busyNxt;
            memReq     <= memReqNxt;
            memWe      <= memWeNxt;
            memAddr    <= memAddrNxt;
            memWdata   <= memWdataNxt;
            memBe      <= memBeNxt;
            wrEn       <= wrEnNxt;
            wrAddr     <= wrAddrNxt;
            wrData     <= wrDataNxt;
            fault      <= faultNxt;
            faultCause <= faultCauseNxt;
            faultAddr  <= faultAddrNxt;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of single requests plus hand-written
// sequences for timeout, late ack and reset during an access.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady, isLoad, isStore;
    logic [2:0]  funct3;
    logic [31:0] baseAddr, offset, storeData;
    logic [4:0]  rdAddr;
    logic        memReq, memWe, memAck;
    logic [31:0] memAddr, memWdata, memRdata;
    logic [3:0]  memBe;
    logic        wrEn, fault, busy;
    logic [4:0]  wrAddr;
    logic [31:0] wrData, faultAddr;
    logic [1:0]  faultCause;

    int ncomp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady),
        .isLoad(isLoad), .isStore(isStore), .funct3(funct3),
        .baseAddr(baseAddr), .offset(offset), .storeData(storeData), .rdAddr(rdAddr),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memBe(memBe), .memAck(memAck), .memRdata(memRdata),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .fault(fault), .faultCause(faultCause), .faultAddr(faultAddr), .busy(busy)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          delay;
        logic        expFault;
        logic [1:0]  expCause;
        logic [31:0] expAddr;
        logic        expWe;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic        expWrEn;
        logic [31:0] expWrData;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] base,
                                logic [31:0] off, logic [31:0] sd, logic [4:0] rd,
                                logic [31:0] rdata, int delay, logic expFault,
                                logic [1:0] expCause, logic [31:0] expAddr, logic expWe,
                                logic [3:0] expBe, logic [31:0] expWdata, logic expWrEn,
                                logic [31:0] expWrData);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.base = base; v.off = off; v.sd = sd;
        v.rd = rd; v.rdata = rdata; v.delay = delay; v.expFault = expFault;
        v.expCause = expCause; v.expAddr = expAddr; v.expWe = expWe; v.expBe = expBe;
        v.expWdata = expWdata; v.expWrEn = expWrEn; v.expWrData = expWrData;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncomp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] sd, input logic [4:0] rd);
        inValid = 1'b1; isLoad = ld; isStore = st; funct3 = f3;
        baseAddr = base; offset = off; storeData = sd; rdAddr = rd;
    endtask

    task automatic idleInputs();
        inValid = 1'b0; isLoad = 1'b0; isStore = 1'b0; funct3 = 3'd0;
        baseAddr = 32'd0; offset = 32'd0; storeData = 32'd0; rdAddr = 5'd0;
    endtask

    // Entered and left just after a falling edge.
    task automatic runVec(input int idx, input vec_t v);
        chk($sformatf("v%0d inReady", idx), 32'(inReady), 32'd1);
        drive(v.ld, v.st, v.f3, v.base, v.off, v.sd, v.rd);
        @(negedge clk);
        idleInputs();
        if (v.expFault) begin
            chk($sformatf("v%0d fault", idx), 32'(fault), 32'd1);
            chk($sformatf("v%0d faultCause", idx), 32'(faultCause), 32'(v.expCause));
            chk($sformatf("v%0d faultAddr", idx), faultAddr, v.expAddr);
            chk($sformatf("v%0d memReq", idx), 32'(memReq), 32'd0);
            chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d faultEnd", idx), 32'(fault), 32'd0);
            chk($sformatf("v%0d memReqAfter", idx), 32'(memReq), 32'd0);
            chk($sformatf("v%0d wrEnAfter", idx), 32'(wrEn), 32'd0);
        end else begin
            for (int i = 0; i <= v.delay; i++) begin
                chk($sformatf("v%0d c%0d memReq", idx, i), 32'(memReq), 32'd1);
                chk($sformatf("v%0d c%0d memAddr", idx, i), memAddr, v.expAddr);
                chk($sformatf("v%0d c%0d memWe", idx, i), 32'(memWe), 32'(v.expWe));
                chk($sformatf("v%0d c%0d memBe", idx, i), 32'(memBe), 32'(v.expBe));
                chk($sformatf("v%0d c%0d memWdata", idx, i), memWdata, v.expWdata);
                chk($sformatf("v%0d c%0d inReady", idx, i), 32'(inReady), 32'd0);
                if (i == v.delay) begin
                    memAck = 1'b1;
                    memRdata = v.rdata;
                end
                @(negedge clk);
            end
            memAck = 1'b0;
            memRdata = 32'h5A5A_5A5A;
            chk($sformatf("v%0d memReqDrop", idx), 32'(memReq), 32'd0);
            if (v.ld) begin
                chk($sformatf("v%0d wrEn", idx), 32'(wrEn), 32'(v.expWrEn));
                if (v.expWrEn) begin
                    chk($sformatf("v%0d wrAddr", idx), 32'(wrAddr), 32'(v.rd));
                    chk($sformatf("v%0d wrData", idx), wrData, v.expWrData);
                end
                chk($sformatf("v%0d inReadyWb", idx), 32'(inReady), 32'd0);
                @(negedge clk);
                chk($sformatf("v%0d wrEnEnd", idx), 32'(wrEn), 32'd0);
            end else begin
                chk($sformatf("v%0d storeWrEn", idx), 32'(wrEn), 32'd0);
            end
            chk($sformatf("v%0d busyEnd", idx), 32'(busy), 32'd0);
        end
    endtask

    initial begin
        //           ld    st    f3      base          off           sd            rd     rdata        dly flt cause  addr          we    be       wdata         wrEn  wrData
        vecs[0]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_1000, 32'h0000_0003, 32'h0,        5'd5,  32'h80FF_FF00, 2, 0, 2'b00, 32'h0000_1000, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hFFFF_FF80);
        vecs[1]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_2000, 32'h0000_0002, 32'h1234_ABCD, 5'd0,  32'h0,        1, 0, 2'b00, 32'h0000_2000, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,        5'd7,  32'hDEAD_BEEF, 0, 0, 2'b00, 32'h0000_0004, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF);
        vecs[3]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0000_0002, 32'h0,        5'd7,  32'h0,        0, 1, 2'b01, 32'h0000_0102, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[4]  = mk(1'b1, 1'b0, 3'b011, 32'h0000_0200, 32'h0000_0000, 32'h0,        5'd7,  32'h0,        0, 1, 2'b10, 32'h0000_0200, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[5]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_0300, 32'h0000_0001, 32'h0,        5'd0,  32'h0000_8100, 1, 0, 2'b00, 32'h0000_0300, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0);
        vecs[6]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_0040, 32'h0000_0001, 32'h0000_00A5, 5'd0,  32'h0,        0, 0, 2'b00, 32'h0000_0040, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 1'b1, 3'b010, 32'h0000_0050, 32'h0000_0004, 32'hCAFE_F00D, 5'd0,  32'h0,        3, 0, 2'b00, 32'h0000_0054, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0);
        vecs[8]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_0060, 32'h0000_0002, 32'h0,        5'd3,  32'h8001_7FFF, 1, 0, 2'b00, 32'h0000_0060, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hFFFF_8001);
        vecs[9]  = mk(1'b1, 1'b0, 3'b101, 32'h0000_0060, 32'h0000_0000, 32'h0,        5'd4,  32'h8001_F00F, 0, 0, 2'b00, 32'h0000_0060, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0000_F00F);
        vecs[10] = mk(1'b1, 1'b1, 3'b000, 32'h0000_0010, 32'h0000_0000, 32'h0,        5'd1,  32'h0,        0, 1, 2'b10, 32'h0000_0010, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[11] = mk(1'b0, 1'b1, 3'b100, 32'h0000_0020, 32'h0000_0000, 32'h0,        5'd0,  32'h0,        0, 1, 2'b10, 32'h0000_0020, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[12] = mk(1'b0, 1'b1, 3'b001, 32'h0000_0071, 32'h0000_0000, 32'h0,        5'd0,  32'h0,        0, 1, 2'b01, 32'h0000_0071, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[13] = mk(1'b1, 1'b0, 3'b011, 32'h0000_0003, 32'h0000_0000, 32'h0,        5'd2,  32'h0,        0, 1, 2'b10, 32'h0000_0003, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[14] = mk(1'b1, 1'b0, 3'b000, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,        5'd9,  32'h7F00_0000, 2, 0, 2'b00, 32'h0000_0FFC, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h0000_007F);

        rst = 1'b1;
        memAck = 1'b0;
        memRdata = 32'd0;
        idleInputs();
        repeat (3) @(negedge clk);

        chk("rst inReady", 32'(inReady), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst memReq", 32'(memReq), 32'd0);
        chk("rst memWe", 32'(memWe), 32'd0);
        chk("rst memAddr", memAddr, 32'd0);
        chk("rst memWdata", memWdata, 32'd0);
        chk("rst memBe", 32'(memBe), 32'd0);
        chk("rst wrEn", 32'(wrEn), 32'd0);
        chk("rst wrAddr", 32'(wrAddr), 32'd0);
        chk("rst wrData", wrData, 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst faultCause", 32'(faultCause), 32'd0);
        chk("rst faultAddr", faultAddr, 32'd0);

        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < NV; k++) runVec(k, vecs[k]);

        // Timeout: four request cycles, then a timeout fault; a late ack is ignored.
        chk("to inReady", 32'(inReady), 32'd1);
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0, 5'd6);
        @(negedge clk);
        idleInputs();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to c%0d memReq", i), 32'(memReq), 32'd1);
            @(negedge clk);
        end
        chk("to fault", 32'(fault), 32'd1);
        chk("to faultCause", 32'(faultCause), 32'd3);
        chk("to faultAddr", faultAddr, 32'h0000_0500);
        chk("to memReq", 32'(memReq), 32'd0);
        memAck = 1'b1;
        memRdata = 32'h1111_2222;
        @(negedge clk);
        chk("to faultEnd", 32'(fault), 32'd0);
        chk("to lateWrEn", 32'(wrEn), 32'd0);
        chk("to inReady2", 32'(inReady), 32'd1);
        chk("to memReq2", 32'(memReq), 32'd0);
        @(negedge clk);
        chk("to idleAckWrEn", 32'(wrEn), 32'd0);
        chk("to idleAckMemReq", 32'(memReq), 32'd0);
        chk("to idleAckBusy", 32'(busy), 32'd0);
        memAck = 1'b0;
        @(negedge clk);

        // Reset during ACCESS, with an ack in the same cycle: reset wins.
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h0, 5'd8);
        @(negedge clk);
        idleInputs();
        chk("ra memReq", 32'(memReq), 32'd1);
        rst = 1'b1;
        memAck = 1'b1;
        memRdata = 32'h3333_4444;
        @(negedge clk);
        rst = 1'b0;
        memAck = 1'b0;
        chk("ra memReq0", 32'(memReq), 32'd0);
        chk("ra inReady", 32'(inReady), 32'd1);
        chk("ra busy", 32'(busy), 32'd0);
        chk("ra wrEn", 32'(wrEn), 32'd0);
        chk("ra fault", 32'(fault), 32'd0);
        @(negedge clk);
        chk("ra wrEn2", 32'(wrEn), 32'd0);
        chk("ra fault2", 32'(fault), 32'd0);
        chk("ra memReq2", 32'(memReq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
